uart_tx_arbiter: RTL and testbench

Sequencing and arbitration front-end for the `uart_top` register port. After reset it programs both UART config registers from parameters. It then shares the UART TX queue among `N_REQ` byte producers using round-robin arbitration, polls the TX-queue-full status before every push, and issues the two-cycle load/push register sequence the UART requires. It is the sole master of the UART register port; UART RX is not serviced in designs that use it.

---
 rtl/uart_tx_arbiter_pkg.sv | 26 ++
 rtl/uart_tx_arbiter_rr.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg
// Shared definitions for the UART TX arbiter: the arbiter FSM state type,
// the UART register-select map and the status bit that reports a full
// TX queue.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_CFG_A,
    ST_CFG_B,
    ST_IDLE,
    ST_POLL,
    ST_LOAD,
    ST_PUSH
  } uart_arb_state_t;

  localparam logic [2:0] UART_REG_TXDATA = 3'h0;
  localparam logic [2:0] UART_REG_RXDATA = 3'h1;
  localparam logic [2:0] UART_REG_CFG_A  = 3'h2;
  localparam logic [2:0] UART_REG_CFG_B  = 3'h3;
  localparam logic [2:0] UART_REG_STATUS = 3'h5;
  localparam logic [2:0] UART_REG_IF     = 3'h6;

  localparam int UART_STATUS_TXFULL_BIT = 15;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a winner starts
// one past the previous winner and wraps modulo N, so every requester is
// served within N grants.
// Ports:
//   req       - request vector, one bit per requester
//   last      - index of the previous winner
//   grant     - one-hot grant (all zero when nothing is requested)
//   grant_idx - binary index of the winner
//   any       - at least one request is present
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  // Walk the candidates in priority order; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Sole master of the UART register port. After reset it writes both UART
// config registers, then shares the TX queue among N_REQ byte producers
// with round-robin arbitration. Every byte is preceded by a status poll and
// written with the two-cycle load/push sequence the UART needs.
// Ports:
//   clk, reset       - clock; synchronous active-low reset
//   req_valid/data   - per-requester byte offers (byte i at [8i+7:8i])
//   req_ready        - one-hot acceptance pulse, only in IDLE
//   cfg_reload       - pulse in IDLE to rerun the config writes
//   busy             - high in every state except IDLE
//   uart_we/re       - UART write / read strobes
//   uart_regsel/din  - UART register select and write data
//   uart_dout        - UART read data (status is read in POLL)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         N_REQ = 2,
  parameter logic [7:0] CFG_A = 8'h08,
  parameter logic [7:0] CFG_B = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               cfg_reload,
  output logic               busy,
  output logic               uart_we,
  output logic               uart_re,
  output logic [2:0]         uart_regsel,
  output logic [31:0]        uart_din,
  input  logic [31:0]        uart_dout
);

  localparam int IDX_W = $clog2(N_REQ);

  uart_arb_state_t  state;
  uart_arb_state_t  state_next;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic             grant_fire;
  logic             tx_full;
  logic [7:0]       data_q;
  logic [7:0]       sel_byte;
  logic             unused_dout;

  assign tx_full     = uart_dout[UART_STATUS_TXFULL_BIT];
  assign unused_dout = ^{uart_dout[31:16], uart_dout[14:0]};

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Byte of the current winner, picked with constant part-selects.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_byte = req_data[8*i +: 8];
      end
    end
  end

  // State, arbitration pointer and captured byte. A reset in the middle of a
  // transfer drops the captured byte and restarts the config writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_CFG_A;
      last   <= IDX_W'(N_REQ - 1);
      data_q <= '0;
    end else begin
      state <= state_next;
      if (grant_fire) begin
        last   <= grant_idx;
        data_q <= sel_byte;
      end
    end
  end

  // Next state and output decode. Outputs are held at their quiet values
  // while reset is asserted so the UART never sees a config write during
  // reset, even though the state register already sits in CFG_A.
  always_comb begin
    state_next  = state;
    uart_we     = 1'b0;
    uart_re     = 1'b0;
    uart_regsel = UART_REG_STATUS;
    uart_din    = '0;
    req_ready   = '0;
    busy        = 1'b1;
    grant_fire  = 1'b0;

    case (state)
      ST_CFG_A: begin
        uart_we     = 1'b1;
        uart_regsel = UART_REG_CFG_A;
        uart_din    = {8'h00, CFG_A, 16'h0000};
        state_next  = ST_CFG_B;
      end
      ST_CFG_B: begin
        uart_we     = 1'b1;
        uart_regsel = UART_REG_CFG_B;
        uart_din    = {CFG_B, 24'h000000};
        state_next  = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (cfg_reload) begin
          state_next = ST_CFG_A;
        end else if (grant_any) begin
          req_ready  = grant;
          grant_fire = 1'b1;
          state_next = ST_POLL;
        end
      end
      ST_POLL: begin
        if (!tx_full) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        uart_we     = 1'b1;
        uart_regsel = UART_REG_TXDATA;
        uart_din    = {24'h000000, data_q};
        state_next  = ST_PUSH;
      end
      ST_PUSH: begin
        uart_we     = 1'b1;
        uart_re     = 1'b1;
        uart_regsel = UART_REG_TXDATA;
        uart_din    = {24'h000000, data_q};
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_CFG_A;
      end
    endcase

    if (!reset) begin
      uart_we     = 1'b0;
      uart_re     = 1'b0;
      uart_regsel = UART_REG_STATUS;
      uart_din    = '0;
      req_ready   = '0;
      busy        = 1'b1;
      grant_fire  = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with three requesters. A
// behavioural model tracks where the register sequence is and what byte is
// in flight; a compare process checks every output on every falling edge.
// Directed scenarios pin the model with literal expectations, then a long
// randomized run exercises arbitration, full-queue stalls, reloads and
// resets.
module tb_uart_tx_arbiter;

  localparam int         TB_N    = 3;
  localparam logic [7:0] P_CFG_A = 8'h3C;
  localparam logic [7:0] P_CFG_B = 8'hA4;

  logic              clk;
  logic              reset;
  logic [TB_N-1:0]   req_valid;
  logic [8*TB_N-1:0] req_data;
  logic [TB_N-1:0]   req_ready;
  logic              cfg_reload;
  logic              busy;
  logic              uart_we;
  logic              uart_re;
  logic [2:0]        uart_regsel;
  logic [31:0]       uart_din;
  logic [31:0]       uart_dout;

  int n_checks = 0;
  int n_errors = 0;

  // Model: config writes still owed (0 = A due, 1 = B due, 2 = done),
  // whether a byte is in flight and how far it got, arbitration pointer.
  bit         m_valid     = 1'b0;
  int         m_cfg       = 0;
  bit         m_busy_byte = 1'b0;
  int         m_phase     = 0;
  logic [7:0] m_byte      = 8'h00;
  int         m_last      = TB_N - 1;
  bit         m_granted   = 1'b0;
  int         m_gidx      = 0;
  int         m_pushes    = 0;
  int         dut_pushes  = 0;

  uart_tx_arbiter #(
    .N_REQ (TB_N),
    .CFG_A (P_CFG_A),
    .CFG_B (P_CFG_B)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cfg_reload  (cfg_reload),
    .busy        (busy),
    .uart_we     (uart_we),
    .uart_re     (uart_re),
    .uart_regsel (uart_regsel),
    .uart_din    (uart_din),
    .uart_dout   (uart_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rrWinner(input logic [TB_N-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= TB_N; k++) begin
      idx = (last + k) % TB_N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [TB_N-1:0] v, input logic rl, input logic full);
    @(posedge clk);
    #1;
    reset         = rst;
    req_valid     = v;
    cfg_reload    = rl;
    uart_dout     = $urandom;
    uart_dout[15] = full;
  endtask

  // Model advance on each rising edge.
  always @(posedge clk) begin
    m_granted <= 1'b0;
    if (!reset) begin
      m_valid     <= 1'b1;
      m_cfg       <= 0;
      m_busy_byte <= 1'b0;
      m_last      <= TB_N - 1;
    end else if (m_valid) begin
      if (m_cfg < 2) begin
        m_cfg <= m_cfg + 1;
      end else if (m_busy_byte) begin
        if (m_phase == 0) begin
          if (!uart_dout[15]) m_phase <= 1;
        end else if (m_phase == 1) begin
          m_phase <= 2;
        end else begin
          m_busy_byte <= 1'b0;
          m_pushes    <= m_pushes + 1;
        end
      end else if (cfg_reload) begin
        m_cfg <= 0;
      end else if (req_valid != '0) begin
        m_last      <= rrWinner(req_valid, m_last);
        m_byte      <= req_data[8*rrWinner(req_valid, m_last) +: 8];
        m_busy_byte <= 1'b1;
        m_phase     <= 0;
        m_granted   <= 1'b1;
        m_gidx      <= rrWinner(req_valid, m_last);
      end
    end
  end

  // Compare process: expected outputs derived from the model each cycle.
  initial begin
    logic            e_we, e_re, e_busy;
    logic [2:0]      e_sel;
    logic [31:0]     e_din;
    logic [TB_N-1:0] e_ready;
    int              w;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e_we = 1'b0; e_re = 1'b0; e_sel = 3'd5; e_din = '0; e_ready = '0; e_busy = 1'b1;
        if (reset) begin
          if (m_cfg == 0) begin
            e_we = 1'b1; e_sel = 3'd2; e_din = {8'h00, P_CFG_A, 16'h0000};
          end else if (m_cfg == 1) begin
            e_we = 1'b1; e_sel = 3'd3; e_din = {P_CFG_B, 24'h000000};
          end else if (m_busy_byte) begin
            if (m_phase >= 1) begin
              e_we = 1'b1; e_sel = 3'd0; e_din = {24'h000000, m_byte};
              e_re = (m_phase == 2);
            end
          end else begin
            e_busy = 1'b0;
            if (!cfg_reload) begin
              w = rrWinner(req_valid, m_last);
              if (w >= 0) e_ready[w] = 1'b1;
            end
          end
        end
        checkOutput("we", uart_we, e_we);
        checkOutput("re", uart_re, e_re);
        checkOutput("regsel", uart_regsel, e_sel);
        checkOutput("din", uart_din, e_din);
        checkOutput("req_ready", req_ready, e_ready);
        checkOutput("busy", busy, e_busy);
        if (reset && uart_we && uart_re) dut_pushes++;
      end
    end
  end

  initial begin
    int         grant_cyc[$];
    logic [7:0] pushed[$];
    logic [7:0] exp_seq [4];
    int         poll_cycles;
    int         extra_grants;
    int         old_push;
    bit         seen_load;

    reset      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    cfg_reload = 1'b0;
    uart_dout  = '0;

    // Reset held for three edges, then released.
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_we", uart_we, 1'b0);
    checkOutput("rst_sel", uart_regsel, 3'd5);
    checkOutput("rst_busy", busy, 1'b1);
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("cfgA_we", uart_we, 1'b1);
    checkOutput("cfgA_sel", uart_regsel, 3'd2);
    checkOutput("cfgA_byte", uart_din[23:16], 8'h3C);
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("cfgB_we", uart_we, 1'b1);
    checkOutput("cfgB_sel", uart_regsel, 3'd3);
    checkOutput("cfgB_byte", uart_din[31:24], 8'hA4);

    // Single request from requester 0.
    req_data[7:0] = 8'hA5;
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("first_idle_busy", busy, 1'b0);
    checkOutput("first_grant", req_ready, 3'b001);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("poll_we", uart_we, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("load_wr", {uart_we, uart_re}, 2'b10);
    checkOutput("load_din", uart_din, 32'h000000A5);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("push_wr", {uart_we, uart_re}, 2'b11);
    checkOutput("push_sel", uart_regsel, 3'd0);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("back_idle", busy, 1'b0);

    // Two requesters held valid. Requester 0 won last, so 1 goes first.
    req_data[7:0]  = 8'h11;
    req_data[15:8] = 8'h22;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      @(negedge clk);
      if (req_ready != '0) grant_cyc.push_back(i);
      if (uart_we && uart_re) pushed.push_back(uart_din[7:0]);
    end
    exp_seq = '{8'h22, 8'h11, 8'h22, 8'h11};
    checkOutput("rr_grant_count", grant_cyc.size(), 4);
    checkOutput("rr_push_count", pushed.size(), 4);
    for (int i = 1; i < grant_cyc.size(); i++)
      checkOutput("rr_grant_gap", grant_cyc[i] - grant_cyc[i-1], 4);
    for (int i = 0; i < pushed.size() && i < 4; i++)
      checkOutput("rr_push_order", pushed[i], exp_seq[i]);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);

    // Full TX queue for ten cycles starting at the grant.
    req_data[7:0]  = 8'hA5;
    req_data[15:8] = 8'h77;
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("full_grant", req_ready, 3'b001);
    poll_cycles  = 0;
    extra_grants = 0;
    seen_load    = 1'b0;
    for (int i = 1; i <= 20 && !seen_load; i++) begin
      applyStimulus(1'b1, (i <= 10) ? 3'b010 : 3'b000, 1'b0, (i <= 9));
      @(negedge clk);
      if (req_ready != '0) extra_grants++;
      if (uart_we) seen_load = 1'b1;
      else poll_cycles++;
    end
    checkOutput("full_load_seen", seen_load, 1'b1);
    checkOutput("full_poll_cycles", poll_cycles, 10);
    checkOutput("full_no_grant", extra_grants, 0);
    checkOutput("full_load_din", uart_din, 32'h000000A5);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_push", {uart_we, uart_re}, 2'b11);

    // Reload takes priority over a pending request.
    req_data[7:0] = 8'h5C;
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("reload_no_grant", req_ready, 3'b000);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reload_cfgA", uart_regsel, 3'd2);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reload_cfgB", uart_regsel, 3'd3);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reload_grant", req_ready, 3'b001);

    // Reset arriving during LOAD loses the byte.
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mid_load_din", uart_din, 32'h0000005C);
    #1 reset = 1'b0;
    old_push = 0;
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mid_rst_we", uart_we, 1'b0);
    checkOutput("mid_rst_sel", uart_regsel, 3'd5);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    if (uart_we && uart_re) old_push++;
    checkOutput("mid_rel_cfgA", uart_regsel, 3'd2);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    if (uart_we && uart_re) old_push++;
    checkOutput("mid_rel_cfgB", uart_regsel, 3'd3);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    if (uart_we && uart_re) old_push++;
    checkOutput("mid_rel_idle", busy, 1'b0);
    checkOutput("mid_no_old_push", old_push, 0);

    // Randomized traffic honouring the requester contract.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset         = ($urandom_range(0, 99) != 0);
      cfg_reload    = ($urandom_range(0, 29) == 0);
      uart_dout     = $urandom;
      uart_dout[15] = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < TB_N; i++) begin
        if (m_granted && m_gidx == i) begin
          req_valid[i]       = 1'($urandom_range(0, 1));
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    checkOutput("push_total", dut_pushes, m_pushes);
    checkOutput("random_traffic_flowed", (m_pushes > 10), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
